// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared definitions for the stack engine
// Purpose : FSM state encoding, default geometry and op-code decoding used by
//           stack_mem_ctrl and stack_ram.
// Contents: DEF_N / DEF_W / DEF_SP_RST defaults, state_t plus ST_* encodings,
//           OP_* request codes, and decode_op().
package stack_pkg;

    localparam int DEF_N      = 9;
    localparam int DEF_W      = 16;
    localparam int DEF_SP_RST = (1 << DEF_N) - 1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_PUSH_WR  = 2'd1;
    localparam state_t ST_POP_RD   = 2'd2;
    localparam state_t ST_POP_DONE = 2'd3;

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_PEEK = 2'd3;

    // A request is valid only when exactly one operation bit is set.
    // Any combination of bits, or no bit at all, decodes to OP_NONE.
    function automatic logic [1:0] decode_op(input logic psh, input logic pop, input logic peek);
        logic [1:0] w_op;
        case ({psh, pop, peek})
            3'b100:  w_op = OP_PUSH;
            3'b010:  w_op = OP_POP;
            3'b001:  w_op = OP_PEEK;
            default: w_op = OP_NONE;
        endcase
        return w_op;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - stack storage, one synchronous write port and one synchronous read port
// Purpose : W x 2**N word memory. It has no reset, so its contents survive a
//           controller reset.
// Ports   : clk      - clock
//           i_we     - write enable;  i_waddr / i_wdata - write address and data
//           i_re     - read enable;   i_raddr - read address
//           o_rdata  - read data, registered, valid the cycle after i_re
module stack_ram
    import stack_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         i_we,
    input  logic [N-1:0] i_waddr,
    input  logic [W-1:0] i_wdata,
    input  logic         i_re,
    input  logic [N-1:0] i_raddr,
    output logic [W-1:0] o_rdata
);

    logic [W-1:0] r_mem [0:(1 << N)-1];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_mem_ctrl.sv
// rtl/stack_mem_ctrl.sv - push/pop stack engine with stack pointer, RAM and error flags
// Purpose : Accepts push and pop requests from the control unit. It owns the
//           stack pointer and the stack RAM. The stack grows downward from
//           SP_RST: a push pre-decrements sp and a pop post-increments sp.
// Ports   : clk, rst_n (asynchronous, active low)
//           op_valid/op_psh/op_pop - request; accepted when op_valid && op_ready
//           op_peek                - present only with STACK_PEEK_EN defined
//           din                    - push data, sampled in the accept cycle
//           op_ready               - high only in IDLE
//           dout/dout_valid        - popped data and its one-cycle strobe
//           sp/full/empty          - stack pointer and its status flags
//           err_ovf/err_unf        - one-cycle pulses for a push while full / a pop while empty
// Config  : STACK_PEEK_EN adds a peek request. A peek reads the top entry and
//           leaves sp unchanged.
module stack_mem_ctrl
    import stack_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int W      = DEF_W,
    parameter int SP_RST = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         op_valid,
    input  logic         op_psh,
    input  logic         op_pop,
`ifdef STACK_PEEK_EN
    input  logic         op_peek,
`endif
    input  logic [W-1:0] din,
    output logic         op_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic [N-1:0] sp,
    output logic         full,
    output logic         empty,
    output logic         err_ovf,
    output logic         err_unf
);

    localparam logic [N-1:0] SP_EMPTY = N'(SP_RST);

    state_t       r_state;
    logic [N-1:0] r_sp;
    logic [W-1:0] r_din;
    logic [W-1:0] r_dout;
    logic         r_dout_valid;
    logic         r_err_ovf;
    logic         r_err_unf;
    logic         r_peek;

    logic         w_peek;
    logic         w_accept;
    logic [1:0]   w_op;
    logic         w_full;
    logic         w_empty;
    logic         w_ram_we;
    logic         w_ram_re;
    logic [N-1:0] w_ram_waddr;
    logic [W-1:0] w_ram_q;

`ifdef STACK_PEEK_EN
    assign w_peek = op_peek;
`else
    assign w_peek = 1'b0;
`endif

    assign w_full   = (r_sp == '0);
    assign w_empty  = (r_sp == SP_EMPTY);
    assign w_accept = op_valid && (r_state == ST_IDLE);
    assign w_op     = decode_op(op_psh, op_pop, w_peek);

    // The write enable is decoded from the state. An asynchronous reset in
    // PUSH_WR therefore drops it before the edge, and no partial push is
    // stored in the RAM.
    assign w_ram_we    = (r_state == ST_PUSH_WR);
    assign w_ram_waddr = r_sp - N'(1);
    assign w_ram_re    = (r_state == ST_POP_RD);

    stack_ram #(
        .N (N),
        .W (W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (r_din),
        .i_re    (w_ram_re),
        .i_raddr (r_sp),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sp         <= SP_EMPTY;
            r_din        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            r_peek       <= 1'b0;
        end else begin
            r_dout_valid <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_PUSH: begin
                                r_din <= din;
                                if (w_full) r_err_ovf <= 1'b1;
                                else        r_state   <= ST_PUSH_WR;
                            end
                            OP_POP, OP_PEEK: begin
                                r_peek <= (w_op == OP_PEEK);
                                if (w_empty) r_err_unf <= 1'b1;
                                else         r_state   <= ST_POP_RD;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_PUSH_WR: begin
                    r_sp    <= r_sp - N'(1);
                    r_state <= ST_IDLE;
                end
                ST_POP_RD: begin
                    r_state <= ST_POP_DONE;
                end
                ST_POP_DONE: begin
                    r_dout       <= w_ram_q;
                    r_dout_valid <= 1'b1;
                    if (!r_peek) r_sp <= r_sp + N'(1);
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign op_ready   = (r_state == ST_IDLE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign sp         = r_sp;
    assign full       = w_full;
    assign empty      = w_empty;
    assign err_ovf    = r_err_ovf;
    assign err_unf    = r_err_unf;

endmodule
